// File: rtl/rvm_pcu.sv
// Program counter unit: sequences instruction fetches and applies branch/trap redirects.
// Latency: a fetch completes on the edge that samples imem_ack; a redirect starts its fetch the next cycle.
// Backpressure: imem_req/imem_addr held until imem_ack; HOLD keeps pc/instr until advance or redirect.
module rvm_pcu #(
    parameter logic [31:0] RVM_PCU_RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic        imem_error,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic        core_stall,
    input  logic        pc_advance,
    input  logic        pc_branch,
    input  logic [31:0] branch_target,
    input  logic        mret,
    input  logic [31:0] mepc,
    input  logic        goto_mtvec,
    input  logic [31:2] mtvec,
    output logic        trap_iaddr_misalign,
    output logic        trap_iaddr_fault
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FETCH    = 3'd1;
    localparam logic [2:0] S_HOLD     = 3'd2;
    localparam logic [2:0] S_FLUSH    = 3'd3;
    localparam logic [2:0] S_TRAPWAIT = 3'd4;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [2:0]  state;
    logic [2:0]  state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] fetch_addr;
    logic [31:0] mtvec_addr;
    logic        instr_load;
    logic        misalign_nxt;
    logic        fault_nxt;

    assign mtvec_addr  = {mtvec, 2'b00};
    assign imem_req    = (state == S_FETCH) || (state == S_FLUSH);
    assign imem_addr   = fetch_addr;
    assign instr_valid = (state == S_HOLD);
    assign core_stall  = !instr_valid;

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        instr_load   = 1'b0;
        misalign_nxt = 1'b0;
        fault_nxt    = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                // A trap redirect wins over a coincident response, which is then dropped.
                if (goto_mtvec) begin
                    pc_nxt    = mtvec_addr;
                    state_nxt = S_FLUSH;
                end else if (imem_ack) begin
                    if (imem_error) begin
                        fault_nxt = 1'b1;
                        state_nxt = S_TRAPWAIT;
                    end else begin
                        instr_load = 1'b1;
                        state_nxt  = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (goto_mtvec) begin
                    pc_nxt    = mtvec_addr;
                    state_nxt = S_FETCH;
                end else if (mret) begin
                    if (mepc[1:0] != 2'b00) begin
                        misalign_nxt = 1'b1;
                        state_nxt    = S_TRAPWAIT;
                    end else begin
                        pc_nxt    = mepc;
                        state_nxt = S_FETCH;
                    end
                end else if (pc_branch) begin
                    if (branch_target[1:0] != 2'b00) begin
                        misalign_nxt = 1'b1;
                        state_nxt    = S_TRAPWAIT;
                    end else begin
                        pc_nxt    = branch_target;
                        state_nxt = S_FETCH;
                    end
                end else if (pc_advance) begin
                    pc_nxt    = pc + 32'd4;
                    state_nxt = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (goto_mtvec) begin
                    pc_nxt = mtvec_addr;
                end
                if (imem_ack) begin
                    state_nxt = S_FETCH;
                end
            end
            S_TRAPWAIT: begin
                if (goto_mtvec) begin
                    pc_nxt    = mtvec_addr;
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state               <= S_IDLE;
            pc                  <= RVM_PCU_RESET_ADDR;
            fetch_addr          <= RVM_PCU_RESET_ADDR;
            instr               <= NOP_INSTR;
            trap_iaddr_misalign <= 1'b0;
            trap_iaddr_fault    <= 1'b0;
        end else begin
            state               <= state_nxt;
            pc                  <= pc_nxt;
            trap_iaddr_misalign <= misalign_nxt;
            trap_iaddr_fault    <= fault_nxt;
            if (instr_load) begin
                instr <= imem_rdata;
            end
            // Bus address is captured only when a new fetch begins, so it stays put until ack.
            if ((state_nxt == S_FETCH) && (state != S_FETCH)) begin
                fetch_addr <= pc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_rvm_pcu.sv
// Bench for rvm_pcu: directed scenarios plus randomized stimulus against a behavioural model.
module tb_rvm_pcu;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        imem_error = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        core_stall;
    logic        pc_advance = 1'b0;
    logic        pc_branch = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        mret = 1'b0;
    logic [31:0] mepc = 32'h0;
    logic        goto_mtvec = 1'b0;
    logic [31:2] mtvec = 30'h0;
    logic        trap_iaddr_misalign;
    logic        trap_iaddr_fault;

    int n_vec = 0;
    int n_err = 0;

    rvm_pcu dut (
        .clk                 (clk),
        .resetn              (resetn),
        .imem_req            (imem_req),
        .imem_addr           (imem_addr),
        .imem_ack            (imem_ack),
        .imem_error          (imem_error),
        .imem_rdata          (imem_rdata),
        .pc                  (pc),
        .instr               (instr),
        .instr_valid         (instr_valid),
        .core_stall          (core_stall),
        .pc_advance          (pc_advance),
        .pc_branch           (pc_branch),
        .branch_target       (branch_target),
        .mret                (mret),
        .mepc                (mepc),
        .goto_mtvec          (goto_mtvec),
        .mtvec               (mtvec),
        .trap_iaddr_misalign (trap_iaddr_misalign),
        .trap_iaddr_fault    (trap_iaddr_fault)
    );

    initial forever #5 clk = ~clk;

    // Behavioural reference: the pipeline phase seen by the core plus its visible registers.
    typedef enum int {P_IDLE, P_FETCH, P_HOLD, P_FLUSH, P_TRAP} phase_t;
    phase_t      m_ph;
    logic [31:0] m_pc, m_fa, m_ins;
    logic        m_mis, m_flt;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        imem_ack = 1'b0; imem_error = 1'b0; imem_rdata = 32'h0;
        pc_advance = 1'b0; pc_branch = 1'b0; branch_target = 32'h0;
        mret = 1'b0; mepc = 32'h0; goto_mtvec = 1'b0; mtvec = 30'h0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic finish_fetch(input logic [31:0] d);
        imem_ack = 1'b1; imem_error = 1'b0; imem_rdata = d;
        tick();
        imem_ack = 1'b0;
    endtask

    task automatic boot(input logic [31:0] d);
        apply_reset();
        tick();
        finish_fetch(d);
    endtask

    task automatic jump(input logic [31:0] a, input logic [31:0] d);
        pc_branch = 1'b1; branch_target = a;
        tick();
        pc_branch = 1'b0;
        finish_fetch(d);
    endtask

    task automatic test_reset();
        clear_inputs();
        resetn = 1'b0;
        tick();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want 00000000", pc); end
        n_vec++; if (instr !== 32'h0000_0013) begin n_err++; $display("FAIL reset_instr: got %h want 00000013", instr); end
        n_vec++; if (instr_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_vec++; if (core_stall !== 1'b1) begin n_err++; $display("FAIL reset_stall: got %b want 1", core_stall); end
        n_vec++; if ({trap_iaddr_misalign, trap_iaddr_fault} !== 2'b00) begin n_err++; $display("FAIL reset_traps: got %b%b want 00", trap_iaddr_misalign, trap_iaddr_fault); end
    endtask

    task automatic test_basic_fetch();
        apply_reset();
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req); end
        tick();
        for (int w = 0; w < 3; w++) begin
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL boot_fetch_%0d: got req=%b addr=%h want req=1 addr=00000000", w, imem_req, imem_addr); end
            if (w < 2) tick();
        end
        finish_fetch(32'h00A0_0093);
        n_vec++; if (instr_valid !== 1'b1 || core_stall !== 1'b0) begin n_err++; $display("FAIL boot_hold: got valid=%b stall=%b want 1/0", instr_valid, core_stall); end
        n_vec++; if (instr !== 32'h00A0_0093) begin n_err++; $display("FAIL boot_instr: got %h want 00a00093", instr); end
        n_vec++; if (pc !== 32'h0 || imem_req !== 1'b0) begin n_err++; $display("FAIL boot_pc: got pc=%h req=%b want 00000000/0", pc, imem_req); end
    endtask

    task automatic test_branch_priority();
        boot(32'h1111_1111);
        pc_advance = 1'b1; pc_branch = 1'b1; branch_target = 32'h0000_0100;
        tick();
        pc_advance = 1'b0; pc_branch = 1'b0;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL prio_addr: got req=%b addr=%h want 1/00000100", imem_req, imem_addr); end
        finish_fetch(32'h2222_2222);
        n_vec++; if (pc !== 32'h100 || instr !== 32'h2222_2222) begin n_err++; $display("FAIL prio_hold: got pc=%h instr=%h want 00000100/22222222", pc, instr); end
        jump(32'hFFFF_FFFC, 32'h3333_3333);
        n_vec++; if (pc !== 32'hFFFF_FFFC || instr_valid !== 1'b1) begin n_err++; $display("FAIL wrap_pre: got pc=%h valid=%b want fffffffc/1", pc, instr_valid); end
        pc_advance = 1'b1;
        tick();
        pc_advance = 1'b0;
        n_vec++; if (imem_addr !== 32'h0 || pc !== 32'h0 || imem_req !== 1'b1) begin n_err++; $display("FAIL wrap_fetch: got addr=%h pc=%h req=%b want 0/0/1", imem_addr, pc, imem_req); end
        finish_fetch(32'h4444_4444);
    endtask

    task automatic test_misalign();
        boot(32'h0);
        jump(32'h40, 32'h5555_5555);
        pc_branch = 1'b1; branch_target = 32'h0000_0102;
        tick();
        pc_branch = 1'b0;
        n_vec++; if (trap_iaddr_misalign !== 1'b1 || trap_iaddr_fault !== 1'b0) begin n_err++; $display("FAIL mis_pulse: got mis=%b flt=%b want 1/0", trap_iaddr_misalign, trap_iaddr_fault); end
        n_vec++; if (pc !== 32'h40 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL mis_state: got pc=%h valid=%b req=%b want 00000040/0/0", pc, instr_valid, imem_req); end
        pc_advance = 1'b1;
        tick();
        pc_advance = 1'b0;
        n_vec++; if (trap_iaddr_misalign !== 1'b0 || pc !== 32'h40 || imem_req !== 1'b0) begin n_err++; $display("FAIL mis_wait: got mis=%b pc=%h req=%b want 0/00000040/0", trap_iaddr_misalign, pc, imem_req); end
        goto_mtvec = 1'b1; mtvec = 30'h70;
        tick();
        goto_mtvec = 1'b0;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h1C0 || pc !== 32'h1C0) begin n_err++; $display("FAIL mis_vector: got req=%b addr=%h pc=%h want 1/000001c0/000001c0", imem_req, imem_addr, pc); end
        finish_fetch(32'h6666_6666);
    endtask

    task automatic test_flush();
        boot(32'h0);
        pc_branch = 1'b1; branch_target = 32'h80;
        tick();
        pc_branch = 1'b0;
        goto_mtvec = 1'b1; mtvec = 30'h90;
        tick();
        goto_mtvec = 1'b0;
        for (int w = 0; w < 3; w++) begin
            n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_err++; $display("FAIL flush_hold_%0d: got req=%b addr=%h want 1/00000080", w, imem_req, imem_addr); end
            if (w < 2) tick();
        end
        n_vec++; if (pc !== 32'h240 || instr_valid !== 1'b0) begin n_err++; $display("FAIL flush_pc: got pc=%h valid=%b want 00000240/0", pc, instr_valid); end
        imem_ack = 1'b1; imem_error = 1'b1; imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0; imem_error = 1'b0;
        n_vec++; if (trap_iaddr_fault !== 1'b0) begin n_err++; $display("FAIL flush_nofault: got %b want 0", trap_iaddr_fault); end
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h240 || instr === 32'hBAD0_BAD0) begin n_err++; $display("FAIL flush_refetch: got req=%b addr=%h instr=%h want 1/00000240/not bad0bad0", imem_req, imem_addr, instr); end
        finish_fetch(32'h7777_7777);
        n_vec++; if (instr !== 32'h7777_7777 || pc !== 32'h240) begin n_err++; $display("FAIL flush_done: got instr=%h pc=%h want 77777777/00000240", instr, pc); end
    endtask

    task automatic test_fault();
        boot(32'h0);
        pc_branch = 1'b1; branch_target = 32'h200;
        tick();
        pc_branch = 1'b0;
        imem_ack = 1'b1; imem_error = 1'b1; imem_rdata = 32'h8888_8888;
        tick();
        imem_ack = 1'b0; imem_error = 1'b0;
        n_vec++; if (trap_iaddr_fault !== 1'b1 || trap_iaddr_misalign !== 1'b0) begin n_err++; $display("FAIL fault_pulse: got flt=%b mis=%b want 1/0", trap_iaddr_fault, trap_iaddr_misalign); end
        n_vec++; if (pc !== 32'h200 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL fault_state: got pc=%h valid=%b req=%b want 00000200/0/0", pc, instr_valid, imem_req); end
        mret = 1'b1; mepc = 32'h400;
        tick();
        mret = 1'b0;
        n_vec++; if (trap_iaddr_fault !== 1'b0 || instr_valid !== 1'b0 || pc !== 32'h200) begin n_err++; $display("FAIL fault_wait: got flt=%b valid=%b pc=%h want 0/0/00000200", trap_iaddr_fault, instr_valid, pc); end
        goto_mtvec = 1'b1; mtvec = 30'h10;
        tick();
        goto_mtvec = 1'b0;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL fault_vector: got req=%b addr=%h want 1/00000040", imem_req, imem_addr); end
        finish_fetch(32'h9999_9999);
    endtask

    task automatic test_reset_mid_fetch();
        boot(32'hABCD_0001);
        pc_branch = 1'b1; branch_target = 32'h300;
        tick();
        pc_branch = 1'b0;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h300) begin n_err++; $display("FAIL rst_pre: got req=%b addr=%h want 1/00000300", imem_req, imem_addr); end
        #2 resetn = 1'b0;
        #1;
        n_vec++; if (imem_req !== 1'b0 || pc !== 32'h0 || imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_async: got req=%b pc=%h addr=%h want 0/0/0", imem_req, pc, imem_addr); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || instr_valid !== 1'b0) begin n_err++; $display("FAIL rst_restart: got req=%b addr=%h valid=%b want 1/0/0", imem_req, imem_addr, instr_valid); end
        n_vec++; if (instr !== 32'h0000_0013) begin n_err++; $display("FAIL rst_idle_ack: got instr=%h want 00000013", instr); end
        finish_fetch(32'h0BAD_F00D);
        n_vec++; if (instr !== 32'h0BAD_F00D || pc !== 32'h0) begin n_err++; $display("FAIL rst_refetch: got instr=%h pc=%h want 0badf00d/0", instr, pc); end
    endtask

    // Advances the reference by one clock using the inputs currently driven.
    task automatic model_step();
        phase_t      np;
        logic [31:0] npc, nins, tvec, tgt;
        logic        nmis, nflt;
        np = m_ph; npc = m_pc; nins = m_ins; nmis = 1'b0; nflt = 1'b0;
        tvec = {mtvec, 2'b00};
        case (m_ph)
            P_IDLE: np = P_FETCH;
            P_FETCH: begin
                if (goto_mtvec) begin npc = tvec; np = P_FLUSH; end
                else if (imem_ack && imem_error) begin nflt = 1'b1; np = P_TRAP; end
                else if (imem_ack) begin nins = imem_rdata; np = P_HOLD; end
            end
            P_HOLD: begin
                if (goto_mtvec) begin npc = tvec; np = P_FETCH; end
                else if (mret || pc_branch) begin
                    tgt = mret ? mepc : branch_target;
                    if (tgt % 4 != 0) begin nmis = 1'b1; np = P_TRAP; end
                    else begin npc = tgt; np = P_FETCH; end
                end else if (pc_advance) begin npc = m_pc + 32'd4; np = P_FETCH; end
            end
            P_FLUSH: begin
                if (goto_mtvec) npc = tvec;
                if (imem_ack) np = P_FETCH;
            end
            default: begin
                if (goto_mtvec) begin npc = tvec; np = P_FETCH; end
            end
        endcase
        if (np == P_FETCH && m_ph != P_FETCH) m_fa = npc;
        m_ph = np; m_pc = npc; m_ins = nins; m_mis = nmis; m_flt = nflt;
    endtask

    task automatic test_random();
        int          wait_cnt;
        logic [31:0] t;
        logic        exp_req, exp_valid;
        apply_reset();
        m_ph = P_IDLE; m_pc = 32'h0; m_fa = 32'h0; m_ins = 32'h0000_0013; m_mis = 1'b0; m_flt = 1'b0;
        wait_cnt = $urandom_range(0, 3);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (imem_req && wait_cnt == 0) begin
                imem_ack = 1'b1; imem_error = ($urandom_range(0, 7) == 0);
                wait_cnt = $urandom_range(0, 3);
            end else begin
                imem_ack = 1'b0; imem_error = $urandom_range(0, 1) == 1;
                if (imem_req) wait_cnt--;
            end
            imem_rdata = $urandom;
            goto_mtvec = ($urandom_range(0, 9) == 0);
            mret       = ($urandom_range(0, 5) == 0);
            pc_branch  = ($urandom_range(0, 3) == 0);
            pc_advance = ($urandom_range(0, 1) == 0);
            mtvec      = 30'($urandom);
            t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00; branch_target = t;
            t = $urandom; if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00; mepc = t;
            model_step();
            tick();
            exp_req   = (m_ph == P_FETCH) || (m_ph == P_FLUSH);
            exp_valid = (m_ph == P_HOLD);
            n_vec++; if (imem_req !== exp_req) begin n_err++; $display("FAIL rnd_req@%0d: got %b want %b", cyc, imem_req, exp_req); end
            if (exp_req) begin
                n_vec++; if (imem_addr !== m_fa) begin n_err++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, imem_addr, m_fa); end
            end
            n_vec++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc@%0d: got %h want %h", cyc, pc, m_pc); end
            n_vec++; if (instr !== m_ins) begin n_err++; $display("FAIL rnd_instr@%0d: got %h want %h", cyc, instr, m_ins); end
            n_vec++; if (instr_valid !== exp_valid || core_stall !== !exp_valid) begin n_err++; $display("FAIL rnd_valid@%0d: got valid=%b stall=%b want valid=%b", cyc, instr_valid, core_stall, exp_valid); end
            n_vec++; if (trap_iaddr_misalign !== m_mis) begin n_err++; $display("FAIL rnd_misalign@%0d: got %b want %b", cyc, trap_iaddr_misalign, m_mis); end
            n_vec++; if (trap_iaddr_fault !== m_flt) begin n_err++; $display("FAIL rnd_fault@%0d: got %b want %b", cyc, trap_iaddr_fault, m_flt); end
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_branch_priority();
        test_misalign();
        test_flush();
        test_fault();
        test_reset_mid_fetch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
